uart_echo_buf: RTL and testbench

Buffered, mode-selectable echo core between the UART receiver's AXI-stream master and the UART transmitter's AXI-stream slave. Incoming bytes are written into a parametrised FIFO so that bursts from the host are not lost while the transmitter is busy. An output stage pops the FIFO and applies a per-byte transform (pass, uppercase, CR->CRLF expansion or mute). The block also exposes the FIFO fill level, a sticky overflow flag and accept/drop counters for debug.

---
 rtl/uart_echo_buf.sv | 170 +++++++++++++++++
 tb/tb_uart_echo_buf.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buf.sv
`default_nettype none
// ---- uart_echo_buf : FIFO-buffered UART echo with pass/upper/CRLF/mute transform ----
// ---- rev 1.0 ----
module uart_echo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              mode_i,
  input  logic                    clear_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic [CNT_WIDTH-1:0]    accept_count_o,
  output logic [CNT_WIDTH-1:0]    drop_count_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DATA  = 2'd1,
    ST_LF    = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, level;
  logic                  fifo_full, fifo_empty, mute;
  logic                  push, pop, drop, load, load_lf;
  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] out_data, pop_byte, xform_byte, lf_byte;
  logic                  pop_is_cr, cr_held, in_ready;
  logic [CNT_WIDTH-1:0]  acc_cnt, drop_cnt;
  logic                  ovf;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mute       = (mode_i == 2'b11);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = s_axis_tvalid && (!fifo_full || pop) && !mute;
  assign drop       = s_axis_tvalid && !push;
  assign pop_byte   = mem[rd_ptr[AW-1:0]];

  generate
    if (DATA_WIDTH == 8) begin : g_byte_xform
      always_comb begin
        xform_byte = pop_byte;
        if (mode_i == 2'b01 && pop_byte >= 8'h61 && pop_byte <= 8'h7A)
          xform_byte = pop_byte - 8'h20;
      end
      assign pop_is_cr = (mode_i == 2'b10) && (pop_byte == 8'h0D);
      assign lf_byte   = 8'h0A;
    end else begin : g_pass_only
      assign xform_byte = pop_byte;
      assign pop_is_cr  = 1'b0;
      assign lf_byte    = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    load_lf  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_axis_tready) begin
          if (cr_held) begin
            load_lf  = 1'b1;
            state_nx = ST_LF;
          end else if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
      end
      ST_LF: begin
        if (m_axis_tready) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            load     = 1'b1;
            state_nx = ST_DATA;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // The CR flag is captured with the byte so a later mode change cannot alter the pending LF.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      cr_held  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_data <= xform_byte;
        cr_held  <= pop_is_cr;
      end else if (load_lf) begin
        out_data <= lf_byte;
        cr_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clear_i) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push && !(&acc_cnt))  acc_cnt  <= acc_cnt + 1'b1;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (drop && !mute)        ovf      <= 1'b1;
    end
  end

  assign s_axis_tready  = in_ready;
  assign m_axis_tdata   = out_data;
  assign m_axis_tvalid  = (state != ST_EMPTY);
  assign level_o        = level;
  assign overflow_o     = ovf;
  assign accept_count_o = acc_cnt;
  assign drop_count_o   = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buf.sv
`default_nettype none
// ---- tb_uart_echo_buf : directed + randomized check of uart_echo_buf against a byte-stream model ----
// ---- rev 1.0 ----
module tb_uart_echo_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        clear;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] acc_cnt, drop_cnt;

  logic        sm_s_ready, sm_m_valid, sm_overflow;
  logic [7:0]  sm_m_data;
  logic [4:0]  sm_level;
  logic [1:0]  sm_acc, sm_drop;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;
  int          acc_exp;

  always #5 clk = ~clk;

  uart_echo_buf #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .clear_i(clear),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .level_o(level), .overflow_o(overflow),
    .accept_count_o(acc_cnt), .drop_count_o(drop_cnt)
  );

  // Narrow-counter copy sharing all inputs, used only to see saturation.
  uart_echo_buf #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .clear_i(clear),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(sm_s_ready),
    .m_axis_tdata(sm_m_data), .m_axis_tvalid(sm_m_valid), .m_axis_tready(m_ready),
    .level_o(sm_level), .overflow_o(sm_overflow),
    .accept_count_o(sm_acc), .drop_count_o(sm_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected output stream derived from the mode rules.
  task automatic push_exp(input logic [7:0] b, input logic [1:0] m);
    if (m == 2'b01 && b >= "a" && b <= "z") exp_q.push_back(b - 8'd32);
    else                                     exp_q.push_back(b);
    if (m == 2'b10 && b == 8'h0D) exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || level != 0 || m_valid) && n < 800) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Output monitor: ordering against the model and stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 1);
        chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        chk("out_avail", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) chk("out_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    rst_n = 1'b0; mode = 2'b00; clear = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_acc", {16'd0, acc_cnt}, 0);
    chk("rst_drop", {16'd0, drop_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("s_ready_up", {31'd0, s_ready}, 1);

    // Pass mode, back-to-back bytes, first-byte latency
    push_exp(8'h41, 2'b00); push_exp(8'h42, 2'b00); push_exp(8'h43, 2'b00);
    s_valid = 1'b1; s_data = 8'h41;
    tick();
    chk("lat_valid_early", {31'd0, m_valid}, 0);
    chk("lat_level", {27'd0, level}, 1);
    s_data = 8'h42;
    tick();
    chk("lat_valid", {31'd0, m_valid}, 1);
    chk("lat_data", {24'd0, m_data}, 32'h41);
    s_data = 8'h43;
    tick();
    s_valid = 1'b0;
    wait_drain(0);
    chk("pass_acc", {16'd0, acc_cnt}, 3);
    chk("pass_level", {27'd0, level}, 0);

    // Uppercase mode
    mode = 2'b01;
    push_exp(8'h61, 2'b01); push_exp(8'h5A, 2'b01); push_exp(8'h7B, 2'b01);
    s_valid = 1'b1;
    s_data = 8'h61; tick();
    s_data = 8'h5A; tick();
    s_data = 8'h7B; tick();
    s_valid = 1'b0;
    wait_drain(0);
    chk("sat_acc", {30'd0, sm_acc}, 3);

    // Mode change while the output is stalled must not disturb held data
    m_ready = 1'b0;
    push_exp(8'h61, 2'b01);
    send(8'h61);
    tick(); tick();
    mode = 2'b00;
    tick();
    chk("stall_valid", {31'd0, m_valid}, 1);
    chk("stall_data", {24'd0, m_data}, 32'h41);
    m_ready = 1'b1;
    wait_drain(0);

    // CR -> CRLF expansion
    pulse_clear();
    chk("clr_acc", {16'd0, acc_cnt}, 0);
    mode = 2'b10;
    push_exp(8'h0D, 2'b10); push_exp(8'h31, 2'b10);
    s_valid = 1'b1;
    s_data = 8'h0D; tick();
    s_data = 8'h31; tick();
    s_valid = 1'b0;
    wait_drain(0);
    chk("crlf_acc", {16'd0, acc_cnt}, 2);

    // Overflow: 20 bytes against a stalled transmitter
    pulse_clear();
    mode = 2'b00;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i < 17) push_exp(b, 2'b00);
      s_valid = 1'b1; s_data = b;
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("ovf_level", {27'd0, level}, 16);
    chk("ovf_acc", {16'd0, acc_cnt}, 17);
    chk("ovf_drop", {16'd0, drop_cnt}, 3);
    chk("ovf_flag", {31'd0, overflow}, 1);
    chk("ovf_valid", {31'd0, m_valid}, 1);
    send(8'hEE); send(8'hEF);
    chk("ovf_drop5", {16'd0, drop_cnt}, 5);
    chk("sat_drop", {30'd0, sm_drop}, 3);
    // Clear coincident with a drop: clear wins
    s_valid = 1'b1; s_data = 8'hAA; clear = 1'b1;
    tick();
    s_valid = 1'b0; clear = 1'b0;
    chk("clrdrop_drop", {16'd0, drop_cnt}, 0);
    chk("clrdrop_ovf", {31'd0, overflow}, 0);
    chk("clrdrop_acc", {16'd0, acc_cnt}, 0);
    chk("clrdrop_level", {27'd0, level}, 16);
    m_ready = 1'b1;
    wait_drain(0);

    // Mute: input dropped without setting overflow
    mode = 2'b11;
    send(8'h11); send(8'h22);
    tick();
    chk("mute_drop", {16'd0, drop_cnt}, 2);
    chk("mute_ovf", {31'd0, overflow}, 0);
    chk("mute_acc", {16'd0, acc_cnt}, 0);
    chk("mute_level", {27'd0, level}, 0);
    chk("mute_valid", {31'd0, m_valid}, 0);
    mode = 2'b00;

    // Randomized bursts with random back-pressure
    pulse_clear();
    acc_exp = 0;
    for (int burst = 0; burst < 12; burst++) begin
      int len;
      mode = 2'($urandom_range(0, 2));
      len  = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 9);
        if (r == 0)     b = 8'h0D;
        else if (r < 4) b = 8'($urandom_range(8'h61, 8'h7A));
        else            b = 8'($urandom);
        push_exp(b, mode);
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
        s_valid = 1'b1; s_data = b;
        m_ready = 1'($urandom_range(0, 1));
        tick();
        acc_exp++;
      end
      s_valid = 1'b0;
      wait_drain(1);
      chk("rnd_acc", {16'd0, acc_cnt}, acc_exp);
      chk("rnd_drop", {16'd0, drop_cnt}, 0);
    end

    // Reset mid-transfer discards everything
    mode = 2'b00;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'(8'h80 + i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("mid_level", {27'd0, level}, 5);
    chk("mid_valid", {31'd0, m_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, m_valid}, 0);
    chk("arst_level", {27'd0, level}, 0);
    chk("arst_s_ready", {31'd0, s_ready}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    push_exp(8'h55, 2'b00);
    send(8'h55);
    wait_drain(0);
    repeat (3) tick();
    chk("post_rst_acc", {16'd0, acc_cnt}, 1);
    chk("post_rst_level", {27'd0, level}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
